// File: rtl/mul_term_gen.sv
// Bit-serial multiplier term generator: walks the set bits of x from the
// top down, fetching one LUT word per bit into a slot array.
module mul_term_gen #(
  parameter int IN_W    = 15,
  parameter int FRAC_W  = 11,
  parameter int TERMS   = 6,
  parameter int MUL_W   = 26,
  parameter int MUL_ONE = 1 << FRAC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               x,
  output logic                          lut_req,
  output logic [$clog2(IN_W)-1:0]       lut_idx,
  input  logic [MUL_W-1:0]              lut_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TERMS*MUL_W-1:0]        mul_flat,
  output logic [$clog2(TERMS+1)-1:0]    term_cnt,
  output logic [IN_W-1:0]               residual,
  output logic                          trunc
);

  localparam int IDX_W = $clog2(IN_W);
  localparam int CNT_W = $clog2(TERMS+1);
  localparam logic [MUL_W-1:0] ONE = MUL_W'(MUL_ONE);

  typedef enum logic [2:0] {
    IDLE, SEL, WAIT, STORE, DONE
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [IN_W-1:0]   r;
  logic [IN_W-1:0]   r_sub;
  logic [CNT_W-1:0]  k;
  logic [IDX_W-1:0]  p_q;
  logic [IDX_W-1:0]  p_lead;
  logic [MUL_W-1:0]  lut_q;
  logic [MUL_W-1:0]  slot [TERMS];
  logic              accept;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign lut_req   = (state == SEL);
  assign lut_idx   = (state == SEL) ? p_lead : p_q;
  assign term_cnt  = k;
  assign residual  = r;
  assign trunc     = (r != '0);

  for (genvar g = 0; g < TERMS; g++) begin : g_flat
    assign mul_flat[g*MUL_W +: MUL_W] = slot[g];
  end

  // Leading-one position of the remaining operand and its removal.
  always_comb begin
    p_lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (r[i]) p_lead = IDX_W'(i);
    end
    r_sub = r - (IN_W'(1) << p_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = (x == '0) ? DONE : SEL;
      SEL:   nxt = WAIT;
      WAIT:  nxt = STORE;
      STORE: begin
        if (k == CNT_W'(TERMS-1) || r_sub == '0) nxt = DONE;
        else                                     nxt = SEL;
      end
      DONE:  if (out_ready) nxt = IDLE;
    endcase
  end

  // Datapath: operand, term counter, LUT capture and slot writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      k     <= '0;
      p_q   <= '0;
      lut_q <= '0;
      for (int j = 0; j < TERMS; j++) slot[j] <= ONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r <= x;
            k <= '0;
            for (int j = 0; j < TERMS; j++) slot[j] <= ONE;
          end
        end
        SEL:  p_q   <= p_lead;
        WAIT: lut_q <= lut_data;
        STORE: begin
          for (int j = 0; j < TERMS; j++) begin
            if (CNT_W'(j) == k) slot[j] <= lut_q;
          end
          r <= r_sub;
          k <= k + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_term_gen.sv
// Scoreboard bench for mul_term_gen with a registered LUT model
// returning 100+lut_idx one cycle after each request.
module tb_mul_term_gen;

  localparam int IN_W  = 15;
  localparam int TERMS = 6;
  localparam int MUL_W = 26;
  localparam logic [MUL_W-1:0] ONE = 26'h800;

  typedef struct {
    int                     cnt;
    logic [IN_W-1:0]        res;
    logic                   tr;
    logic [TERMS*MUL_W-1:0] flat;
    int                     done_cyc;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [IN_W-1:0] x = '0;
  logic lut_req;
  logic [3:0] lut_idx;
  logic [MUL_W-1:0] lut_data = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [TERMS*MUL_W-1:0] mul_flat;
  logic [2:0] term_cnt;
  logic [IN_W-1:0] residual;
  logic trunc;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit seen = 0;
  exp_t sb[$];
  int idx_q[$];

  mul_term_gen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .lut_req(lut_req), .lut_idx(lut_idx), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .mul_flat(mul_flat), .term_cnt(term_cnt),
    .residual(residual), .trunc(trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (lut_req) lut_data <= MUL_W'(100 + int'(lut_idx));
  end

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // LUT request monitor.
  always @(negedge clk) begin
    if (lut_req) begin
      if (idx_q.size() == 0) begin
        total++; bad++;
        $display("FAIL lut_req_unexpected got=%0d want=none", lut_idx);
      end else begin
        chk("lut_idx", 160'(lut_idx), 160'(idx_q.pop_front()));
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (!out_valid) begin
      seen = 0;
    end else if (!seen) begin
      seen = 1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL out_unexpected got=%0h want=none", mul_flat);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("term_cnt", 160'(term_cnt), 160'(e.cnt));
        chk("residual", 160'(residual), 160'(e.res));
        chk("trunc", 160'(trunc), 160'(e.tr));
        chk("mul_flat", 160'(mul_flat), 160'(e.flat));
        chk("latency", 160'(cyc), 160'(e.done_cyc));
      end
    end
  end

  task automatic send(logic [IN_W-1:0] v, int n, logic [23:0] ids,
                      logic [IN_W-1:0] res, logic tr, bit push);
    exp_t e;
    int a;
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL in_ready_timeout got=0 want=1");
      return;
    end
    in_valid = 1;
    x = v;
    @(posedge clk);
    #1;
    in_valid = 0;
    x = '0;
    a = cyc;
    for (int j = 0; j < TERMS; j++) begin
      if (j < n) begin
        idx_q.push_back(int'(ids[4*j +: 4]));
        e.flat[j*MUL_W +: MUL_W] = MUL_W'(100 + int'(ids[4*j +: 4]));
      end else begin
        e.flat[j*MUL_W +: MUL_W] = ONE;
      end
    end
    e.cnt = n;
    e.res = res;
    e.tr = tr;
    e.done_cyc = a + 3 * n;
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && idx_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size() + idx_q.size());
    end
  endtask

  task automatic reset_checks(string tag);
    logic [TERMS*MUL_W-1:0] f;
    for (int j = 0; j < TERMS; j++) f[j*MUL_W +: MUL_W] = ONE;
    chk({tag, "_in_ready"}, 160'(in_ready), 160'(1));
    chk({tag, "_out_valid"}, 160'(out_valid), 160'(0));
    chk({tag, "_lut_req"}, 160'(lut_req), 160'(0));
    chk({tag, "_lut_idx"}, 160'(lut_idx), 160'(0));
    chk({tag, "_term_cnt"}, 160'(term_cnt), 160'(0));
    chk({tag, "_residual"}, 160'(residual), 160'(0));
    chk({tag, "_trunc"}, 160'(trunc), 160'(0));
    chk({tag, "_slots"}, 160'(mul_flat), 160'(f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    reset_checks("rst0");

    send(15'h0C00, 2, 24'h0000AB, 15'h0000, 0, 1);
    drain();
    send(15'h7FFF, 6, 24'h9ABCDE, 15'h01FF, 1, 1);
    drain();
    send(15'h0000, 0, 24'h000000, 15'h0000, 0, 1);
    drain();
    send(15'h0005, 2, 24'h000002, 15'h0000, 0, 1);
    drain();
    send(15'h4001, 2, 24'h00000E, 15'h0000, 0, 1);
    drain();

    out_ready = 0;
    send(15'h0001, 1, 24'h000000, 15'h0000, 0, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("stall_reached_done", 160'(ok), 160'(1));
    in_valid = 1;
    x = 15'h7FFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 160'(out_valid), 160'(1));
      chk("stall_in_ready", 160'(in_ready), 160'(0));
      chk("stall_term_cnt", 160'(term_cnt), 160'(1));
      chk("stall_slot0", 160'(mul_flat[MUL_W-1:0]), 160'(100));
      chk("stall_residual", 160'(residual), 160'(0));
    end
    in_valid = 0;
    x = '0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("hs_in_ready", 160'(in_ready), 160'(1));
    chk("hs_out_valid", 160'(out_valid), 160'(0));
    drain();

    send(15'h0C00, 1, 24'h00000B, 15'h0000, 0, 0);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    reset_checks("rst_mid");
    drain();
    send(15'h0800, 1, 24'h00000B, 15'h0000, 0, 1);
    drain();

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
